// File: rtl/dmem_responder.sv
// Data-memory responder: captures one load/store from the core, forwards it over a
// req/gnt + rvalid backing bus, and returns a single-cycle response (optionally flagged as a timeout).
module dmem_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr_i,
  input  logic [3:0]  dmem_rmask_i,
  input  logic [3:0]  dmem_wmask_i,
  input  logic [31:0] dmem_wdata_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_resp_o,
  output logic        dmem_err_o,
  output logic        dmem_busy_o,
  output logic        bmem_req_o,
  output logic        bmem_we_o,
  output logic [31:0] bmem_addr_o,
  output logic [3:0]  bmem_wmask_o,
  output logic [31:0] bmem_wdata_o,
  input  logic        bmem_gnt_i,
  input  logic        bmem_rvalid_i,
  input  logic [31:0] bmem_rdata_i
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] addr_q;
  logic [3:0]  mask_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic new_req;
  logic can_accept;
  logic timeout_hit;

  assign new_req    = (|dmem_rmask_i) | (|dmem_wmask_i);
  assign can_accept = (state_q == S_IDLE) || (state_q == S_RESP);
  // The REQ cycle that would push the counter to TIMEOUT_CYCLES is the last one.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // Response data/error only live for the RESP cycle.
      rdata_q <= '0;
      err_q   <= 1'b0;

      if (can_accept) begin
        if (new_req) begin
          addr_q  <= {dmem_addr_i[31:2], 2'b00};
          wdata_q <= dmem_wdata_i;
          cnt_q   <= '0;
          state_q <= S_REQ;
          // A load wins over a simultaneous store mask.
          if (|dmem_rmask_i) begin
            we_q   <= 1'b0;
            mask_q <= dmem_rmask_i;
          end else begin
            we_q   <= 1'b1;
            mask_q <= dmem_wmask_i;
          end
        end else begin
          state_q <= S_IDLE;
        end
      end else if (state_q == S_REQ) begin
        if (bmem_gnt_i) begin
          state_q <= S_WAIT;
        end else begin
          if (cnt_q != '1) begin
            cnt_q <= cnt_q + CW'(1);
          end
          if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= S_RESP;
          end
        end
      end else begin
        if (bmem_rvalid_i) begin
          rdata_q <= we_q ? 32'h0 : bmem_rdata_i;
          state_q <= S_RESP;
        end
      end
    end
  end

  assign dmem_resp_o  = (state_q == S_RESP);
  assign dmem_busy_o  = (state_q == S_REQ) || (state_q == S_WAIT);
  assign dmem_rdata_o = rdata_q;
  assign dmem_err_o   = err_q;

  assign bmem_req_o   = (state_q == S_REQ);
  assign bmem_we_o    = we_q;
  assign bmem_addr_o  = addr_q;
  assign bmem_wmask_o = mask_q;
  assign bmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and randomized transactions, each checked against
// expectations derived from grant/rvalid delays and the request masks.
module tb_dmem_responder;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dmem_addr_i, dmem_wdata_i, bmem_rdata_i;
  logic [3:0]  dmem_rmask_i, dmem_wmask_i;
  logic        bmem_gnt_i, bmem_rvalid_i;
  logic [31:0] dmem_rdata_o, bmem_addr_o, bmem_wdata_o;
  logic        dmem_resp_o, dmem_err_o, dmem_busy_o, bmem_req_o, bmem_we_o;
  logic [3:0]  bmem_wmask_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  dmem_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_rmask_i (dmem_rmask_i),
    .dmem_wmask_i (dmem_wmask_i),
    .dmem_wdata_i (dmem_wdata_i),
    .dmem_rdata_o (dmem_rdata_o),
    .dmem_resp_o  (dmem_resp_o),
    .dmem_err_o   (dmem_err_o),
    .dmem_busy_o  (dmem_busy_o),
    .bmem_req_o   (bmem_req_o),
    .bmem_we_o    (bmem_we_o),
    .bmem_addr_o  (bmem_addr_o),
    .bmem_wmask_o (bmem_wmask_o),
    .bmem_wdata_o (bmem_wdata_o),
    .bmem_gnt_i   (bmem_gnt_i),
    .bmem_rvalid_i(bmem_rvalid_i),
    .bmem_rdata_i (bmem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle with no request presented; the responder must sit quietly in IDLE.
  task automatic idle_step();
    dmem_rmask_i  = 4'h0;
    dmem_wmask_i  = 4'h0;
    dmem_addr_i   = $urandom;
    bmem_rvalid_i = 1'($urandom);
    @(negedge clk);
    chk("idle_req",   32'(bmem_req_o),  32'd0);
    chk("idle_busy",  32'(dmem_busy_o), 32'd0);
    chk("idle_resp",  32'(dmem_resp_o), 32'd0);
    chk("idle_rdata", dmem_rdata_o,     32'd0);
    chk("idle_err",   32'(dmem_err_o),  32'd0);
    bmem_rvalid_i = 1'b0;
  endtask

  // Presents a request in the current (IDLE or RESP) cycle and follows it to its RESP cycle.
  // gd = REQ cycles before grant (gd >= TO means grant never comes), rvd = WAIT cycles before rvalid.
  task automatic run_txn(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rvd);
    logic        is_rd;
    logic        tmo;
    logic [3:0]  exp_mask;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    int          req_cycles;
    is_rd     = (rm != 4'h0);
    tmo       = (gd >= TO);
    exp_mask  = is_rd ? rm : wm;
    exp_addr  = a & 32'hFFFF_FFFC;
    exp_rdata = (tmo || !is_rd) ? 32'h0 : rd;
    req_cycles = tmo ? TO : gd + 1;

    dmem_addr_i  = a;
    dmem_rmask_i = rm;
    dmem_wmask_i = wm;
    dmem_wdata_i = wd;
    bmem_gnt_i   = 1'b0;
    @(negedge clk);

    for (int k = 0; k < req_cycles; k++) begin
      chk("req_valid", 32'(bmem_req_o),   32'd1);
      chk("req_busy",  32'(dmem_busy_o),  32'd1);
      chk("req_resp",  32'(dmem_resp_o),  32'd0);
      chk("req_we",    32'(bmem_we_o),    32'(!is_rd));
      chk("req_addr",  bmem_addr_o,       exp_addr);
      chk("req_mask",  32'(bmem_wmask_o), 32'(exp_mask));
      if (!is_rd) chk("req_wdata", bmem_wdata_o, wd);
      // Unrelated requests while busy must be ignored; stray rvalid too.
      dmem_rmask_i  = 4'($urandom);
      dmem_wmask_i  = 4'($urandom);
      dmem_addr_i   = $urandom;
      dmem_wdata_i  = $urandom;
      bmem_gnt_i    = (!tmo && k == gd);
      bmem_rvalid_i = 1'($urandom);
      bmem_rdata_i  = $urandom;
      @(negedge clk);
    end
    bmem_gnt_i = 1'b0;

    if (!tmo) begin
      for (int j = 0; j <= rvd; j++) begin
        chk("wait_req",   32'(bmem_req_o),  32'd0);
        chk("wait_busy",  32'(dmem_busy_o), 32'd1);
        chk("wait_resp",  32'(dmem_resp_o), 32'd0);
        chk("wait_rdata", dmem_rdata_o,     32'd0);
        bmem_rvalid_i = (j == rvd);
        bmem_rdata_i  = (j == rvd) ? rd : $urandom;
        @(negedge clk);
      end
    end
    bmem_rvalid_i = 1'b0;
    dmem_rmask_i  = 4'h0;
    dmem_wmask_i  = 4'h0;

    chk("resp_pulse", 32'(dmem_resp_o), 32'd1);
    chk("resp_busy",  32'(dmem_busy_o), 32'd0);
    chk("resp_req",   32'(bmem_req_o),  32'd0);
    chk("resp_err",   32'(dmem_err_o),  32'(tmo));
    chk("resp_rdata", dmem_rdata_o,     exp_rdata);
    n_txn++;
    $display("txn %0d: %s addr=%h mask=%h gnt_dly=%0d rv_dly=%0d timeout=%0d rdata=%h",
             n_txn, is_rd ? "LD" : "ST", exp_addr, exp_mask, gd, rvd, tmo, dmem_rdata_o);
  endtask

  initial begin
    rst_n = 1'b0;
    dmem_addr_i = '0; dmem_rmask_i = '0; dmem_wmask_i = '0; dmem_wdata_i = '0;
    bmem_gnt_i = 1'b0; bmem_rvalid_i = 1'b0; bmem_rdata_i = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req",   32'(bmem_req_o),   32'd0);
    chk("rst_resp",  32'(dmem_resp_o),  32'd0);
    chk("rst_busy",  32'(dmem_busy_o),  32'd0);
    chk("rst_addr",  bmem_addr_o,       32'd0);
    chk("rst_mask",  32'(bmem_wmask_o), 32'd0);
    chk("rst_rdata", dmem_rdata_o,      32'd0);
    rst_n = 1'b1;
    idle_step();

    // Minimum-latency load
    run_txn(32'h1000_0004, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF, 0, 0);
    idle_step();
    // Byte store with unaligned address
    run_txn(32'h0000_0103, 4'h0, 4'h4, 32'h00AB_0000, 32'h1234_5678, 0, 1);
    idle_step();
    // Grant withheld 5 cycles
    run_txn(32'h2000_0010, 4'h3, 4'h0, 32'h0, 32'hCAFE_F00D, 5, 1);
    idle_step();
    // No grant at all -> timeout after TO REQ cycles
    run_txn(32'h3000_0020, 4'hF, 4'h0, 32'h0, 32'hFFFF_FFFF, TO, 0);
    idle_step();
    // Store then back-to-back load in the store's RESP cycle
    run_txn(32'h0000_0200, 4'h0, 4'hF, 32'h5555_AAAA, 32'h0, 1, 0);
    run_txn(32'h0000_0204, 4'hC, 4'h0, 32'h0, 32'h8765_4321, 0, 2);
    idle_step();
    // Both masks set: the load wins
    run_txn(32'h0000_0300, 4'h1, 4'hF, 32'h9999_9999, 32'h0BAD_CAFE, 2, 0);
    idle_step();

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [3:0] rm, wm;
      int kind;
      kind = int'($urandom_range(0, 2));
      rm = (kind == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      wm = (kind == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      run_txn($urandom, rm, wm, $urandom, $urandom, int'($urandom_range(0, TO)),
              int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 0) idle_step();
    end
    idle_step();

    // Asynchronous reset while waiting for rvalid
    dmem_addr_i = 32'h4000_0000; dmem_rmask_i = 4'hF; dmem_wmask_i = 4'h0;
    @(negedge clk);
    dmem_rmask_i = 4'h0;
    bmem_gnt_i   = 1'b1;
    @(negedge clk);
    bmem_gnt_i = 1'b0;
    chk("pre_rst_busy", 32'(dmem_busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   32'(bmem_req_o),   32'd0);
    chk("arst_busy",  32'(dmem_busy_o),  32'd0);
    chk("arst_resp",  32'(dmem_resp_o),  32'd0);
    chk("arst_addr",  bmem_addr_o,       32'd0);
    chk("arst_we",    32'(bmem_we_o),    32'd0);
    chk("arst_mask",  32'(bmem_wmask_o), 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bmem_rvalid_i = 1'b1;
    bmem_rdata_i  = 32'hABCD_EF01;
    @(negedge clk);
    bmem_rvalid_i = 1'b0;
    chk("post_rst_resp",  32'(dmem_resp_o), 32'd0);
    chk("post_rst_busy",  32'(dmem_busy_o), 32'd0);
    chk("post_rst_rdata", dmem_rdata_o,     32'd0);
    idle_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
